video_in_dma: RTL
=================

VIDEO_IN_DMA -- requirements
Module: video_in_dma

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per line (8-bit pixels, multiple of 4).
REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter BURST, default 4, 32-bit words per bus burst; (WIDTH/4) SHALL be a multiple of BURST.
REQ-004 SHALL have parameter INT_CYCLES, default 3, irq pulse length in clocks (>=1).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 nRST  input  1  reset, asynchronous, active-low.
REQ-007 cfg_en  input  1  capture enable (level).
REQ-008 cfg_addr0 / cfg_addr1  input  32 each  byte base addresses of ping and pong frame buffers.
REQ-009 cfg_stride  input  32  byte distance between line starts in memory.
REQ-010 burst_avail  input  1  FIFO holds >= BURST words.
REQ-011 fifo_data  input  32  FIFO head word (4 pixels); fifo_rd  output  1  pop strobe.
REQ-012 frame_start  output  1  one-cycle pulse that resets upstream blocks.
REQ-013 irq  output  1  frame-done interrupt; buf_sel  output  1  buffer last completed (0=addr0); err_flag  output  1  sticky bus error.
REQ-014 Wishbone master: wb_CYC_O, wb_STB_O, wb_WE_O, wb_LOCK_O outputs 1; wb_SEL_O output 4; wb_ADR_O, wb_DAT_O outputs 32; wb_ACK_I, wb_ERR_I inputs 1.

Function
REQ-015 frame_start SHALL be 1 for exactly the cycle after a 0->1 transition of cfg_en (registered edge detect), also in ERROR.
REQ-016 FSM states: IDLE, WAIT_BURST, WRITE, GAP, DONE, ERROR.
REQ-017 IDLE: on frame_start -> WAIT_BURST; latch base = cfg_addr0, line_addr = base, counters = 0, clear err_flag.
REQ-018 WAIT_BURST: burst_avail=1 -> WRITE; cfg_en=0 -> IDLE (checked first).
REQ-019 WRITE: CYC=STB=1; ADR = line_addr + 4*col_word; DAT = fifo_data; waits indefinitely for ACK or ERR.
REQ-020 ACK in WRITE: fifo_rd=1 that same cycle; col_word, burst_cnt advance; not last of burst -> GAP; last of burst -> WAIT_BURST.
REQ-021 GAP: exactly one cycle, CYC=1, STB=0, fifo_rd=0 (FIFO head settles) -> WRITE.
REQ-022 End of line (last word of line acked): col_word=0, line_addr += cfg_stride (32-bit wrap modulo 2^32).
REQ-023 End of frame (last word of line HEIGHT-1 acked): -> DONE; buf_sel <= current buffer; next base = other buffer address, sampled from cfg_addr0/1 at that cycle.
REQ-024 DONE: irq=1 for INT_CYCLES cycles, then cfg_en=1 -> WAIT_BURST (line_addr = new base), else IDLE.
REQ-025 cfg_en falling mid-burst: burst SHALL complete; exit at next WAIT_BURST; no partial bus cycle ever.
REQ-026 ERR in WRITE: CYC=STB=0 next cycle, fifo_rd=1 (word discarded), err_flag<=1 -> ERROR; ERROR stays until cfg_en=0 -> IDLE.
REQ-027 ACK and ERR together: ERR wins.
REQ-028 Constants: WE=1, SEL=4'hF, LOCK=0; CYC/STB/fifo_rd/irq 0 except as stated.
REQ-029 Counters sized clog2(WIDTH/4), clog2(HEIGHT), clog2(BURST), clog2(INT_CYCLES+1).

Reset
REQ-030 nRST low: state IDLE, all counters 0, line_addr/base 0, CYC=STB=fifo_rd=irq=frame_start=err_flag=buf_sel=0, edge-detect register 0; effect immediate, mid-transfer included.

Verification (WIDTH=16, HEIGHT=2, BURST=2, INT_CYCLES=3, addr0=0x1000, addr1=0x2000, stride=0x40)
REQ-031 cfg_en 0->1, FIFO full, ACK same cycle -> ADR 0x1000,0x1004,0x1008,0x100C,0x1040..0x104C; CYC drops after every 2nd ACK; 8 fifo_rd; irq 3 cycles; buf_sel=0.
REQ-032 cfg_en held -> second frame at 0x2000..0x204C, buf_sel=1; third frame returns to 0x1000.
REQ-033 ACK delayed 5 cycles each -> STB held stable, ADR/DAT unchanged until ACK, one GAP cycle between words.
REQ-034 ERR on 3rd word -> CYC=0 next cycle, err_flag=1, FSM in ERROR; cfg_en 0 then 1 -> err_flag cleared, restart at 0x1000.
REQ-035 burst_avail toggling, cfg_en dropped during burst -> burst finishes, then IDLE, no further CYC.
REQ-036 nRST asserted during WRITE -> CYC/STB 0 immediately; after release, needs new cfg_en rising edge.

Source files
------------

// File: rtl/video_in_dma.sv
// Video capture DMA: drains a pixel FIFO into ping/pong frame buffers over a
// Wishbone master, one burst of BURST words at a time, with frame-done irq.
module video_in_dma #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int BURST      = 4,
  parameter int INT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        cfg_en,
  input  logic [31:0] cfg_addr0,
  input  logic [31:0] cfg_addr1,
  input  logic [31:0] cfg_stride,
  input  logic        burst_avail,
  input  logic [31:0] fifo_data,
  output logic        fifo_rd,
  output logic        frame_start,
  output logic        irq,
  output logic        buf_sel,
  output logic        err_flag,
  output logic        wb_CYC_O,
  output logic        wb_STB_O,
  output logic        wb_WE_O,
  output logic        wb_LOCK_O,
  output logic [3:0]  wb_SEL_O,
  output logic [31:0] wb_ADR_O,
  output logic [31:0] wb_DAT_O,
  input  logic        wb_ACK_I,
  input  logic        wb_ERR_I
);

  localparam int WORDS = WIDTH / 4;
  localparam int CW    = (WORDS > 1)  ? $clog2(WORDS)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW    = (BURST > 1)  ? $clog2(BURST)  : 1;
  localparam int IW    = $clog2(INT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_BURST, WRITE, GAP, DONE, ERROR
  } state_t;

  state_t        state;
  logic          en_d;
  logic          cur_buf;
  logic [31:0]   base;
  logic [31:0]   line_addr;
  logic [CW-1:0] col_word;
  logic [RW-1:0] row;
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] irq_cnt;

  logic last_col, last_row, last_beat, last_irq;

  assign last_col  = (col_word  == CW'(WORDS - 1));
  assign last_row  = (row       == RW'(HEIGHT - 1));
  assign last_beat = (burst_cnt == BW'(BURST - 1));
  assign last_irq  = (irq_cnt   == IW'(INT_CYCLES - 1));

  assign wb_WE_O   = 1'b1;
  assign wb_LOCK_O = 1'b0;
  assign wb_SEL_O  = 4'hF;
  assign wb_ADR_O  = line_addr + 32'({col_word, 2'b00});
  assign wb_DAT_O  = fifo_data;
  // The word on the bus is consumed on the terminating cycle, even an error.
  assign fifo_rd   = (state == WRITE) && (wb_ACK_I || wb_ERR_I);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      en_d        <= 1'b0;
      frame_start <= 1'b0;
      cur_buf     <= 1'b0;
      buf_sel     <= 1'b0;
      err_flag    <= 1'b0;
      irq         <= 1'b0;
      wb_CYC_O    <= 1'b0;
      wb_STB_O    <= 1'b0;
      base        <= '0;
      line_addr   <= '0;
      col_word    <= '0;
      row         <= '0;
      burst_cnt   <= '0;
      irq_cnt     <= '0;
    end else begin
      en_d        <= cfg_en;
      frame_start <= cfg_en & ~en_d;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= WAIT_BURST;
            base      <= cfg_addr0;
            line_addr <= cfg_addr0;
            cur_buf   <= 1'b0;
            col_word  <= '0;
            row       <= '0;
            burst_cnt <= '0;
            irq_cnt   <= '0;
            err_flag  <= 1'b0;
          end
        end
        WAIT_BURST: begin
          if (!cfg_en) begin
            state <= IDLE;
          end else if (burst_avail) begin
            state    <= WRITE;
            wb_CYC_O <= 1'b1;
            wb_STB_O <= 1'b1;
          end
        end
        WRITE: begin
          if (wb_ERR_I) begin
            state    <= ERROR;
            wb_CYC_O <= 1'b0;
            wb_STB_O <= 1'b0;
            err_flag <= 1'b1;
          end else if (wb_ACK_I) begin
            wb_STB_O <= 1'b0;
            if (last_beat) begin
              burst_cnt <= '0;
              wb_CYC_O  <= 1'b0;
              state     <= WAIT_BURST;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
              state     <= GAP;
            end
            // A line always ends on a burst boundary, so DONE overrides WAIT_BURST.
            if (last_col) begin
              col_word  <= '0;
              line_addr <= line_addr + cfg_stride;
              if (last_row) begin
                row     <= '0;
                state   <= DONE;
                irq     <= 1'b1;
                irq_cnt <= '0;
                buf_sel <= cur_buf;
                cur_buf <= ~cur_buf;
                base    <= cur_buf ? cfg_addr0 : cfg_addr1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col_word <= col_word + CW'(1);
            end
          end
        end
        GAP: begin
          state    <= WRITE;
          wb_STB_O <= 1'b1;
        end
        DONE: begin
          if (last_irq) begin
            irq     <= 1'b0;
            irq_cnt <= '0;
            if (cfg_en) begin
              state     <= WAIT_BURST;
              line_addr <= base;
            end else begin
              state <= IDLE;
            end
          end else begin
            irq_cnt <= irq_cnt + IW'(1);
          end
        end
        ERROR: begin
          if (!cfg_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
